led_mode_sequencer: RTL

//  Controller/scheduler for the 6-LED bank: prescales clk into a display tick and sequences the LEDs through 4 modes.

---
 rtl/led_mode_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/led_mode_sequencer.sv
// Six-LED pattern sequencer: prescaled display tick, four modes (up/down/scan/blink), mode and pause buttons.
// Define DEBOUNCE_EN to insert a stability filter of DEBOUNCE_CYCLES between button synchronizer and edge detector.
module led_mode_sequencer #(
   parameter int WAIT_TIME       = 13500000,
   parameter int CNT_W           = 24,
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int DB_W            = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_pause,
   output logic [5:0] led,
   output logic [1:0] mode,
   output logic       paused,
   output logic       tick
);

   typedef enum logic [1:0] {
      MODE_UP    = 2'd0,
      MODE_DOWN  = 2'd1,
      MODE_SCAN  = 2'd2,
      MODE_BLINK = 2'd3
   } mode_t;

   localparam logic [CNT_W-1:0] WAIT_C    = CNT_W'(WAIT_TIME);
   localparam logic             DIR_LEFT  = 1'b0;
   localparam logic             DIR_RIGHT = 1'b1;

   // bit 0 = mode button, bit 1 = pause button
   logic [1:0] btn_raw;
   logic [1:0] press;

   assign btn_raw = {btn_pause, btn_mode};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic sync0_reg;
         logic sync1_reg;
         logic prev_reg;
         logic filt;

         always_ff @(posedge clk) begin
            if (rst) begin
               sync0_reg <= 1'b0;
               sync1_reg <= 1'b0;
               prev_reg  <= 1'b0;
            end else begin
               sync0_reg <= btn_raw[gi];
               sync1_reg <= sync0_reg;
               prev_reg  <= filt;
            end
         end

`ifdef DEBOUNCE_EN
         localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
         logic [DB_W-1:0] db_cnt_reg;
         logic            filt_reg;

         // Count consecutive cycles of disagreement; any agreement restarts the count.
         always_ff @(posedge clk) begin
            if (rst) begin
               db_cnt_reg <= '0;
               filt_reg   <= 1'b0;
            end else if (sync1_reg != filt_reg) begin
               if (db_cnt_reg == DB_LAST) begin
                  filt_reg   <= sync1_reg;
                  db_cnt_reg <= '0;
               end else begin
                  db_cnt_reg <= db_cnt_reg + DB_W'(1);
               end
            end else begin
               db_cnt_reg <= '0;
            end
         end

         assign filt = filt_reg;
`else
         assign filt = sync1_reg;
`endif

         assign press[gi] = filt & ~prev_reg;
      end
   endgenerate

   logic             press_mode;
   logic             press_pause;

   assign press_mode  = press[0];
   assign press_pause = press[1];

   mode_t            mode_reg,   mode_next;
   logic [5:0]       led_reg,    led_next;
   logic             dir_reg,    dir_next;
   logic [CNT_W-1:0] pres_reg,   pres_next;
   logic             paused_reg, paused_next;
   logic             tick_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_reg   <= MODE_UP;
         led_reg    <= 6'h00;
         dir_reg    <= DIR_LEFT;
         pres_reg   <= '0;
         paused_reg <= 1'b0;
      end else begin
         mode_reg   <= mode_next;
         led_reg    <= led_next;
         dir_reg    <= dir_next;
         pres_reg   <= pres_next;
         paused_reg <= paused_next;
      end
   end

   always_comb begin
      mode_next   = mode_reg;
      led_next    = led_reg;
      dir_next    = dir_reg;
      pres_next   = pres_reg;
      paused_next = paused_reg;
      tick_c      = 1'b0;

      if (press_pause) begin
         paused_next = ~paused_reg;
      end

      // A mode step restarts the display period and suppresses a coincident tick.
      if (press_mode) begin
         pres_next = '0;
         case (mode_reg)
            MODE_UP: begin
               mode_next = MODE_DOWN;
               led_next  = 6'h3F;
            end
            MODE_DOWN: begin
               mode_next = MODE_SCAN;
               led_next  = 6'h01;
               dir_next  = DIR_LEFT;
            end
            MODE_SCAN: begin
               mode_next = MODE_BLINK;
               led_next  = 6'h00;
            end
            default: begin
               mode_next = MODE_UP;
               led_next  = 6'h00;
            end
         endcase
      end else if (!paused_reg) begin
         if (pres_reg == WAIT_C) begin
            pres_next = '0;
            tick_c    = 1'b1;
            case (mode_reg)
               MODE_UP: begin
                  led_next = led_reg + 6'd1;
               end
               MODE_DOWN: begin
                  led_next = led_reg - 6'd1;
               end
               MODE_SCAN: begin
                  // Reverse at the end bits so each end is lit for only one tick.
                  if (dir_reg == DIR_LEFT) begin
                     if (led_reg[5]) begin
                        led_next = 6'h10;
                        dir_next = DIR_RIGHT;
                     end else begin
                        led_next = {led_reg[4:0], 1'b0};
                     end
                  end else begin
                     if (led_reg[0]) begin
                        led_next = 6'h02;
                        dir_next = DIR_LEFT;
                     end else begin
                        led_next = {1'b0, led_reg[5:1]};
                     end
                  end
               end
               default: begin
                  led_next = ~led_reg;
               end
            endcase
         end else begin
            pres_next = pres_reg + CNT_W'(1);
         end
      end
   end

   assign led    = led_reg;
   assign mode   = mode_reg;
   assign paused = paused_reg;
   assign tick   = tick_c;

endmodule
